au_writeback: RTL

Result write-back router for the AU datapath, the return path of the operand router. It tracks the destination of every issued AU operation through a tag pipeline matched to AU latency. When each result emerges, it steers the result into a Data Bank write port or into one of the RQ/RD temp registers; RQ/RD feed back to the operand router. It also flags read-after-write hazards on RQ/RD for the sequencer.

---
 rtl/kf_au_pkg.sv | 20 ++
 rtl/au_wb_tag_pipe.sv | 37 +++
 rtl/au_writeback.sv | 71 +++++++
 3 files changed

// File: rtl/kf_au_pkg.sv
// kf_au_pkg: shared AU write-back destination encodings, tag type and saturation constants.
package kf_au_pkg;
  localparam logic [1:0] DST_NONE = 2'b00;
  localparam logic [1:0] DST_BANK = 2'b01;
  localparam logic [1:0] DST_RQ   = 2'b10;
  localparam logic [1:0] DST_RD   = 2'b11;
  // Tag address field is sized for the widest bank; narrower banks zero-extend into it.
  localparam int TAG_AW_MAX = 16;
  typedef struct packed {
    logic                  valid;
    logic [1:0]            dst;
    logic [TAG_AW_MAX-1:0] addr;
  } au_tag_t;
  function automatic logic [63:0] SAT_POS(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] SAT_NEG(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/au_wb_tag_pipe.sv
// au_wb_tag_pipe: LAT-stage destination tag shift register with flush and pending-write flags.
module au_wb_tag_pipe
  import kf_au_pkg::*;
#(
  parameter int AW  = 5,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [1:0]    i_dst,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output au_tag_t       o_commit,
  output logic          o_pend_rq,
  output logic          o_pend_rd,
  output logic          o_any_valid
);
  au_tag_t r_stage [LAT];
  always_ff @(posedge clk)
    if (!rst_n || i_flush) r_stage <= '{default: '0};
    else begin
      r_stage[0] <= '{valid: i_valid && i_dst != DST_NONE, dst: i_dst, addr: TAG_AW_MAX'(i_addr)};
      for (int k = 1; k < LAT; k++) r_stage[k] <= r_stage[k-1];
    end
  always_comb begin
    o_pend_rq   = 1'b0;
    o_pend_rd   = 1'b0;
    o_any_valid = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      o_pend_rq   = o_pend_rq || (r_stage[k].valid && r_stage[k].dst == DST_RQ);
      o_pend_rd   = o_pend_rd || (r_stage[k].valid && r_stage[k].dst == DST_RD);
      o_any_valid = o_any_valid || r_stage[k].valid;
    end
  end
  assign o_commit = r_stage[LAT-1];
endmodule

// File: rtl/au_writeback.sv
// au_writeback: routes AU results to the Data Bank port or RQ/RD and flags RQ/RD read hazards.
// Define AU_WB_SAT_EN to saturate overflowed results using au_ovf/au_sign.
module au_writeback
  import kf_au_pkg::*;
#(
  parameter int W   = 24,
  parameter int AW  = 5,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [1:0]    issue_dst,
  input  logic [AW-1:0] issue_addr,
  input  logic          flush,
  input  logic [W-1:0]  au_result,
  input  logic          au_ovf,
  input  logic          au_sign,
  input  logic          chk_rq,
  input  logic          chk_rd,
  output logic [W-1:0]  RQ,
  output logic [W-1:0]  RD,
  output logic          bank_we,
  output logic [AW-1:0] bank_waddr,
  output logic [W-1:0]  bank_wdata,
  output logic          hazard,
  output logic          busy
);
  au_tag_t      w_tag;
  logic         w_pend_rq, w_pend_rd, w_any_valid, w_commit, w_unused;
  logic [W-1:0] w_wb_val;
  au_wb_tag_pipe #(.AW(AW), .LAT(LAT)) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (issue_valid),
    .i_dst       (issue_dst),
    .i_addr      (issue_addr),
    .i_flush     (flush),
    .o_commit    (w_tag),
    .o_pend_rq   (w_pend_rq),
    .o_pend_rd   (w_pend_rd),
    .o_any_valid (w_any_valid)
  );
`ifdef AU_WB_SAT_EN
  assign w_wb_val = au_ovf ? (au_sign ? W'(SAT_NEG(W)) : W'(SAT_POS(W))) : au_result;
  assign w_unused = ^w_tag.addr;
`else
  assign w_wb_val = au_result;
  assign w_unused = ^{w_tag.addr, au_ovf, au_sign};
`endif
  // A flush in the commit cycle discards that commit as well.
  assign w_commit = w_tag.valid && !flush;
  always_ff @(posedge clk)
    if (!rst_n) begin
      RQ         <= '0;
      RD         <= '0;
      bank_we    <= 1'b0;
      bank_waddr <= '0;
      bank_wdata <= '0;
    end else begin
      bank_we <= w_commit && w_tag.dst == DST_BANK;
      if (w_commit && w_tag.dst == DST_BANK) begin
        bank_waddr <= w_tag.addr[AW-1:0];
        bank_wdata <= w_wb_val;
      end
      if (w_commit && w_tag.dst == DST_RQ) RQ <= w_wb_val;
      if (w_commit && w_tag.dst == DST_RD) RD <= w_wb_val;
    end
  assign hazard = (chk_rq && w_pend_rq) || (chk_rd && w_pend_rd);
  assign busy   = w_any_valid || bank_we;
endmodule
